// File: rtl/nbcac_pkg.sv
// Constants and types shared by the NBCAC packer, encoder and decoder.
package nbcac_pkg;

    localparam int unsigned NBCAC_DATA_W = 22;
    localparam int unsigned NBCAC_CODE_W = 31;

    typedef logic [NBCAC_DATA_W-1:0] nbcac_data_t;

    // Bits needed for a counter that spans 0..max_val inclusive.
    function automatic int unsigned cnt_bits(int unsigned max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/nbcac_bit_accum.sv
// LSB-first bit accumulator: inserts IN_W-bit chunks above the current fill and
// extracts the low WORD_W bits as a word. Bits above fill are always zero.
module nbcac_bit_accum
    import nbcac_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned WORD_W = NBCAC_DATA_W,
    localparam int unsigned ACC_W  = WORD_W + IN_W - 1,
    localparam int unsigned FILL_W = cnt_bits(ACC_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ins_i,
    input  logic [IN_W-1:0]   ins_data_i,
    input  logic              ext_i,
    input  logic              clr_i,
    output logic [WORD_W-1:0] word_o,
    output logic [FILL_W-1:0] fill_o
);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [ACC_W-1:0]  ins_vec;

    assign ins_vec = ACC_W'(ins_data_i) << fill_q;

    always_comb begin
        acc_d  = acc_q;
        fill_d = fill_q;
        if (clr_i) begin
            acc_d  = '0;
            fill_d = '0;
        end else if (ext_i) begin
            acc_d  = acc_q >> WORD_W;
            fill_d = fill_q - FILL_W'(WORD_W);
        end else if (ins_i) begin
            acc_d  = acc_q | ins_vec;
            fill_d = fill_q + FILL_W'(IN_W);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q  <= '0;
            fill_q <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
        end
    end

    assign word_o = acc_q[WORD_W-1:0];
    assign fill_o = fill_q;

endmodule

// File: rtl/nbcac_word_packer.sv
// Packs a byte stream LSB-first into WORD_W-bit words for the NBCAC encoder.
// Optional end-of-frame flush of a zero-padded partial word: NBCAC_PACKER_FLUSH_EN.
module nbcac_word_packer
    import nbcac_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned WORD_W = NBCAC_DATA_W,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_partial,
    output logic [CNT_W-1:0]  word_count
);

    localparam int unsigned FILL_W = cnt_bits(WORD_W + IN_W - 1);

    logic [WORD_W-1:0] acc_word;
    logic [FILL_W-1:0] fill;
    logic              full, slot_free, do_word, do_partial, flush_pend, accept;

    logic [WORD_W-1:0] word_q;
    logic              valid_q, partial_q;
    logic [CNT_W-1:0]  count_q;

    assign full      = fill >= FILL_W'(WORD_W);
    assign slot_free = !valid_q || word_ready;
    assign do_word   = full && slot_free;
    assign in_ready  = !full && !flush_pend;
    assign accept    = in_valid && in_ready;

`ifdef NBCAC_PACKER_FLUSH_EN
    logic flush_pend_q;

    assign flush_pend = flush_pend_q;
    // Full words drain first; the residue goes out only once fill is below a word.
    assign do_partial = flush_pend_q && !full && (fill != '0) && slot_free;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            flush_pend_q <= 1'b0;
        end else if (flush) begin
            flush_pend_q <= 1'b1;
        end else if (fill == '0) begin
            flush_pend_q <= 1'b0;
        end
    end
`else
    logic unused_flush;

    assign unused_flush = flush;
    assign flush_pend   = 1'b0;
    assign do_partial   = 1'b0;
`endif

    nbcac_bit_accum #(
        .IN_W   (IN_W),
        .WORD_W (WORD_W)
    ) u_accum (
        .clk_i      (clock),
        .rst_ni     (rst_n),
        .ins_i      (accept),
        .ins_data_i (in_data),
        .ext_i      (do_word),
        .clr_i      (do_partial),
        .word_o     (acc_word),
        .fill_o     (fill)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            word_q    <= '0;
            valid_q   <= 1'b0;
            partial_q <= 1'b0;
            count_q   <= '0;
        end else begin
            if (do_word || do_partial) begin
                word_q    <= acc_word;
                valid_q   <= 1'b1;
                partial_q <= do_partial;
            end else if (word_ready) begin
                valid_q <= 1'b0;
            end
            if (valid_q && word_ready) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign word_out     = word_q;
    assign word_valid   = valid_q;
    assign word_partial = partial_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_nbcac_word_packer.sv
// Directed bench for nbcac_word_packer: vector table plus multi-cycle sequences,
// with an LSB-first bit-queue reference checking every word handoff.
module tb_nbcac_word_packer;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        word_ready = 1'b1;
    logic        in_ready, word_valid, word_partial;
    logic [21:0] word_out;
    logic [15:0] word_count;
    logic        in_ready_w, word_valid_w, word_partial_w;
    logic [21:0] word_out_w;
    logic [3:0]  word_count_w;

    int checks = 0;
    int errors = 0;
    int stalls = 0;

    bit          bq[$];
    logic [21:0] wq[$];
    logic [15:0] exp_cnt = '0;
    bit          flush_req = 1'b0;
    logic [21:0] mon_w, acc_w;
    logic        mon_p;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [21:0] exp_word;
    } vec_t;
    vec_t vecs[6];

    always #5 clock = ~clock;

    nbcac_word_packer dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .word_partial (word_partial),
        .word_count   (word_count)
    );

    // Narrow counter instance so wrap-around is reachable in a short run.
    nbcac_word_packer #(
        .CNT_W (4)
    ) dut_w (
        .clock        (clock),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready_w),
        .flush        (flush),
        .word_out     (word_out_w),
        .word_valid   (word_valid_w),
        .word_ready   (word_ready),
        .word_partial (word_partial_w),
        .word_count   (word_count_w)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (rst_n) begin
            if (word_valid && word_ready) begin
                mon_w = '0;
                mon_p = 1'b0;
                if (wq.size() > 0) begin
                    mon_w = wq.pop_front();
                end else if (flush_req && bq.size() > 0) begin
                    for (int i = 0; i < bq.size(); i++) mon_w[i] = bq[i];
                    bq.delete();
                    mon_p = 1'b1;
                    flush_req = 1'b0;
                end else begin
                    checks++;
                    errors++;
                    $display("FAIL mon_extra_word: got 0x%0h expected no word", word_out);
                end
                chk("mon_word", 32'(word_out), 32'(mon_w));
                chk("mon_partial", 32'(word_partial), 32'(mon_p));
                chk("mon_word_w", 32'({word_valid_w, word_partial_w, word_out_w}),
                    32'({1'b1, mon_p, mon_w}));
                chk("mon_count", 32'(word_count), 32'(exp_cnt));
                chk("mon_count_w", 32'(word_count_w), 32'(exp_cnt[3:0]));
                exp_cnt++;
            end
            if (in_valid && in_ready) begin
                for (int i = 0; i < 8; i++) bq.push_back(in_data[i]);
                if (bq.size() >= 22) begin
                    acc_w = '0;
                    for (int i = 0; i < 22; i++) acc_w[i] = bq.pop_front();
                    wq.push_back(acc_w);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that released reset.
    task automatic do_reset();
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        bq.delete();
        wq.delete();
        exp_cnt   = '0;
        flush_req = 1'b0;
        #1;
        chk("rst_word_valid", 32'(word_valid), 0);
        chk("rst_word_out", 32'(word_out), 0);
        chk("rst_word_partial", 32'(word_partial), 0);
        chk("rst_word_count", 32'(word_count), 0);
        chk("rst_in_ready", 32'({in_ready, in_ready_w}), 32'h3);
        chk("rst_fill", 32'(dut.u_accum.fill_o), 0);
        repeat (2) @(posedge clock);
        #1 rst_n = 1'b1;
    endtask

    // Offers one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
            stalls++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready 0 expected 1 within 50 cycles");
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 8'hFF, 22'h3FFFFF};
        vecs[1] = '{8'h01, 8'h02, 8'h03, 22'h030201};
        vecs[2] = '{8'h00, 8'h00, 8'h40, 22'h000000};
        vecs[3] = '{8'hA5, 8'h5A, 8'hC3, 22'h035AA5};
        vecs[4] = '{8'h12, 8'h34, 8'hFF, 22'h3F3412};
        vecs[5] = '{8'h80, 8'h00, 8'h3F, 22'h3F0080};

        // Three bytes complete one word; it appears one cycle after the last accept.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            word_ready = 1'b1;
            send_byte(vecs[v].b0);
            send_byte(vecs[v].b1);
            send_byte(vecs[v].b2);
            chk("vec_latency", 32'(word_valid), 0);
            step();
            chk("vec_valid", 32'(word_valid), 1);
            chk("vec_word", 32'(word_out), 32'(vecs[v].exp_word));
            chk("vec_partial", 32'(word_partial), 0);
            chk("vec_fill", 32'(dut.u_accum.fill_o), 2);
            step();
            chk("vec_count", 32'(word_count), 1);
            chk("vec_drained", 32'(word_valid), 0);
        end

        // Streaming: 11 bytes -> 4 words, only the 3 mid-stream transfer stalls.
        do_reset();
        word_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 11; i++) send_byte(8'($urandom_range(0, 255)));
        chk("stream_stalls", 32'(stalls), 3);
        step();
        chk("stream_last_valid", 32'(word_valid), 1);
        chk("stream_fill", 32'(dut.u_accum.fill_o), 0);
        step();
        chk("stream_count", 32'(word_count), 4);
        chk("stream_model_count", 32'(exp_cnt), 4);
        chk("stream_no_pending", 32'(wq.size()), 0);

        // Backpressure: first word held, second word waits in the accumulator.
        do_reset();
        word_ready = 1'b0;
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_word", 32'(word_out), 32'h332211);
        chk("bp_fill", 32'(dut.u_accum.fill_o), 26);
        repeat (3) step();
        chk("bp_hold_word", 32'(word_out), 32'h332211);
        chk("bp_hold_valid", 32'({word_valid, in_ready}), 32'h2);
        word_ready = 1'b1;
        step();
        chk("bp_second_word", 32'(word_out), 32'h195510);
        chk("bp_second_valid", 32'(word_valid), 1);
        chk("bp_fill_after", 32'(dut.u_accum.fill_o), 4);
        step();
        chk("bp_count", 32'(word_count), 2);
        chk("bp_in_ready_after", 32'(in_ready), 1);

        // Flush of a single residual byte.
        do_reset();
        word_ready = 1'b1;
        send_byte(8'hA5);
        chk("fl_no_word", 32'(word_valid), 0);
`ifdef NBCAC_PACKER_FLUSH_EN
        flush_req = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_in_ready_pend", 32'(in_ready), 0);
        step();
        chk("fl_word", 32'(word_out), 32'h0000A5);
        chk("fl_valid", 32'({word_valid, word_partial}), 32'h3);
        chk("fl_fill", 32'(dut.u_accum.fill_o), 0);
        chk("fl_in_ready_hold", 32'(in_ready), 0);
        step();
        chk("fl_in_ready_back", 32'(in_ready), 1);
        chk("fl_count", 32'(word_count), 1);
`else
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (3) step();
        chk("fl_ignored_valid", 32'(word_valid), 0);
        chk("fl_ignored_ready", 32'(in_ready), 1);
        chk("fl_ignored_fill", 32'(dut.u_accum.fill_o), 8);
`endif

        // Counter wrap: 44 bytes -> 16 words; the 4-bit instance wraps to 0.
        do_reset();
        word_ready = 1'b1;
        for (int i = 0; i < 44; i++) send_byte(8'(i * 37 + 5));
        repeat (2) step();
        chk("wrap_count", 32'(word_count), 16);
        chk("wrap_count_w", 32'(word_count_w), 0);
        chk("wrap_no_pending", 32'(wq.size()), 0);

        // Reset mid-word discards the held word and the residue.
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'hFF);
        chk("mid_valid", 32'(word_valid), 1);
        chk("mid_fill", 32'(dut.u_accum.fill_o), 18);
        do_reset();
        word_ready = 1'b1;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        step();
        chk("mid_new_word", 32'(word_out), 32'h030201);
        chk("mid_new_valid", 32'(word_valid), 1);
        step();
        chk("mid_new_count", 32'(word_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1);
    end

endmodule
